// File: rtl/calc_pkg.sv
// Shared key codes, op codes and FSM encodings for the calculator key sequencer.
package calc_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_SAR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic [4:0] KEY_DIGIT_MAX = 5'h09;
    localparam logic [4:0] KEY_EQUALS    = 5'h1E;
    localparam logic [4:0] KEY_CLEAR     = 5'h1F;

    typedef enum logic [2:0] {
        ST_ENTRY_A,
        ST_PUT_A,
        ST_ENTRY_B,
        ST_PUT_B,
        ST_SETTLE,
        ST_PUT_R,
        ST_SHOW,
        ST_CLEAR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } put_phase_t;

    function automatic logic is_digit(input logic [4:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

    // 0x17 would map to the reserved op and is deliberately not an operator.
    function automatic logic is_operator(input logic [4:0] code);
        return (code[4:3] == 2'b10) && (code[2:0] != OP_RSVD);
    endfunction

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_PUT_A) || (s == ST_PUT_B) || (s == ST_SETTLE) ||
               (s == ST_PUT_R) || (s == ST_CLEAR);
    endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Decimal operand accumulator: acc*10+d with overflow rejection, plus load and clear.
module decimal_accumulator
    import calc_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [N-1:0]       load_value,
    input  logic               digit_en,
    input  logic [DIGIT_W-1:0] digit,
    output logic [N-1:0]       acc,
    output logic [N-1:0]       acc_next,
    output logic               overflow
);

    logic [N+3:0] acc_ext;
    logic [N+3:0] product;
    logic         overflow_next;

    always_comb begin
        acc_ext       = {4'b0000, acc};
        // Four spare bits hold 10*(2^N-1)+9 without wrap, so any set high bit means overflow.
        product       = (acc_ext << 3) + (acc_ext << 1) + {{N{1'b0}}, digit};
        acc_next      = acc;
        overflow_next = overflow;
        if (clr) begin
            acc_next      = '0;
            overflow_next = 1'b0;
        end else if (load) begin
            acc_next = load_value;
        end else if (digit_en) begin
            if (product[N+3:N] != 4'd0) begin
                overflow_next = 1'b1;
            end else begin
                acc_next = product[N-1:0];
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            acc      <= acc_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad-to-arithmetic-unit sequencer: operand entry, A/B/R load strobes, settle timing, display.
// Define CALC_CHAIN_EN to let an operator in SHOW reuse the result as the next A operand.
//
// state    | meaning
// ENTRY_A  | collecting digits of operand A
// PUT_A    | setup/strobe/hold of LoadA with acc on the bus
// ENTRY_B  | collecting digits of operand B, operator may be replaced
// PUT_B    | setup/strobe/hold of LoadB with acc on the bus
// SETTLE   | SETTLE_CYCLES with Op and bus frozen for the unit's datapath
// PUT_R    | LoadR strobe
// SHOW     | Display follows Result
// CLEAR    | AuReset pulse, then back to ENTRY_A
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int N             = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         KeyValid,
    input  logic [4:0]   KeyCode,
    output logic         KeyReady,
    input  logic [N-1:0] Result,
    output logic [N-1:0] OperandOut,
    output logic         LoadA,
    output logic         LoadB,
    output logic         LoadR,
    output logic [2:0]   Op,
    output logic         AuReset,
    output logic [N-1:0] Display,
    output logic         Overflow,
    output logic         Busy
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    state_t       state, state_n;
    put_phase_t   phase, phase_n;
    logic [CW-1:0] settle_cnt, settle_cnt_n;
    logic [2:0]   op_n;
    logic [N-1:0] bus_n;

    logic         key_clear, key_take, key_digit, key_oper, key_equals;
    logic         acc_clr, acc_load, acc_digit;
    logic [N-1:0] acc_load_value, acc, acc_next;

    assign key_clear  = KeyValid && (KeyCode == KEY_CLEAR);
    assign key_take   = KeyValid && KeyReady && !key_clear;
    assign key_digit  = key_take && is_digit(KeyCode);
    assign key_oper   = key_take && is_operator(KeyCode);
    assign key_equals = key_take && (KeyCode == KEY_EQUALS);

    decimal_accumulator #(.N(N)) u_acc (
        .clk_sys    (Clock),
        .rst        (Reset),
        .clr        (acc_clr),
        .load       (acc_load),
        .load_value (acc_load_value),
        .digit_en   (acc_digit),
        .digit      (KeyCode[DIGIT_W-1:0]),
        .acc        (acc),
        .acc_next   (acc_next),
        .overflow   (Overflow)
    );

    always_comb begin
        state_n        = state;
        phase_n        = phase;
        settle_cnt_n   = settle_cnt;
        op_n           = Op;
        bus_n          = OperandOut;
        acc_clr        = 1'b0;
        acc_load       = 1'b0;
        acc_load_value = '0;
        acc_digit      = 1'b0;

        if (key_clear) begin
            state_n = ST_CLEAR;
            phase_n = PH_SETUP;
            bus_n   = '0;
            acc_clr = 1'b1;
        end else begin
            case (state)
                ST_ENTRY_A: begin
                    if (key_digit) begin
                        acc_digit = 1'b1;
                    end else if (key_oper) begin
                        op_n    = KeyCode[2:0];
                        state_n = ST_PUT_A;
                        phase_n = PH_SETUP;
                        bus_n   = acc;
                    end
                end
                ST_ENTRY_B: begin
                    if (key_digit) begin
                        acc_digit = 1'b1;
                    end else if (key_oper) begin
                        op_n = KeyCode[2:0];
                    end else if (key_equals) begin
                        state_n = ST_PUT_B;
                        phase_n = PH_SETUP;
                        bus_n   = acc;
                    end
                end
                ST_PUT_A, ST_PUT_B: begin
                    case (phase)
                        PH_SETUP:  phase_n = PH_STROBE;
                        PH_STROBE: phase_n = PH_HOLD;
                        default: begin
                            acc_clr      = 1'b1;
                            phase_n      = PH_SETUP;
                            settle_cnt_n = SETTLE_LAST;
                            state_n      = (state == ST_PUT_A) ? ST_ENTRY_B : ST_SETTLE;
                        end
                    endcase
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state_n = ST_PUT_R;
                    end else begin
                        settle_cnt_n = settle_cnt - CW'(1);
                    end
                end
                ST_PUT_R: state_n = ST_SHOW;
                ST_SHOW: begin
                    if (key_digit) begin
                        acc_load       = 1'b1;
                        acc_load_value = {{(N-DIGIT_W){1'b0}}, KeyCode[DIGIT_W-1:0]};
                        state_n        = ST_ENTRY_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (key_oper) begin
                        op_n    = KeyCode[2:0];
                        state_n = ST_PUT_A;
                        phase_n = PH_SETUP;
                        bus_n   = Result;
                    end
`endif
                end
                ST_CLEAR: state_n = ST_ENTRY_A;
                default:  state_n = ST_ENTRY_A;
            endcase
        end
    end

    // Strobes and flags are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ST_ENTRY_A;
            phase      <= PH_SETUP;
            settle_cnt <= '0;
            Op         <= OP_ADD;
            OperandOut <= '0;
            LoadA      <= 1'b0;
            LoadB      <= 1'b0;
            LoadR      <= 1'b0;
            AuReset    <= 1'b0;
            Display    <= '0;
            Busy       <= 1'b0;
            KeyReady   <= 1'b1;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            settle_cnt <= settle_cnt_n;
            Op         <= op_n;
            OperandOut <= bus_n;
            LoadA      <= (state_n == ST_PUT_A) && (phase_n == PH_STROBE);
            LoadB      <= (state_n == ST_PUT_B) && (phase_n == PH_STROBE);
            LoadR      <= (state_n == ST_PUT_R);
            AuReset    <= (state_n == ST_CLEAR);
            Display    <= ((state == ST_SHOW) && (state_n == ST_SHOW)) ? Result : acc_next;
            Busy       <= is_busy_state(state_n);
            KeyReady   <= !is_busy_state(state_n);
        end
    end

endmodule
